// File: rtl/control_unit_pkg.sv
// Shared definitions for the sequential calculator control unit: opcodes,
// FSM state encoding and the default operand width.
package control_unit_pkg;

    localparam int DEFAULT_DATA_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/control_unit_seq_if.sv
// Request/response bundle between the operand registers (master) and the
// sequential control unit (slave).
interface control_unit_seq_if
    import control_unit_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int OP_W   = 2
);
    logic                  start;
    logic [OP_W-1:0]       input_Operator;
    logic [DATA_W-1:0]     operand_a;
    logic [DATA_W-1:0]     operand_b;
    logic                  busy;
    logic                  done;
    logic [2*DATA_W-1:0]   result;
    logic                  err;

    modport master (
        output start, input_Operator, operand_a, operand_b,
        input  busy, done, result, err
    );

    modport slave (
        input  start, input_Operator, operand_a, operand_b,
        output busy, done, result, err
    );
endinterface

// File: rtl/control_unit_iter.sv
// Bit-serial step datapath: LSB-first shift-add multiply and, when
// CONTROL_UNIT_DIV_EN is defined, MSB-first restoring division.
module control_unit_iter #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                load,
    input  logic                step,
`ifdef CONTROL_UNIT_DIV_EN
    input  logic                is_div,
`endif
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] res_next
);
    logic [DATA_W-1:0] acc_q, sreg_q, opnd_q;
    logic [DATA_W-1:0] acc_n, sreg_n;
    logic [DATA_W:0]   add_sum;
`ifdef CONTROL_UNIT_DIV_EN
    logic [DATA_W:0]   shifted;
    logic              ge;
`endif

    // res_next is the value after the current step, so the final step can be
    // captured into the result register on the same edge.
    always_comb begin
        add_sum = {1'b0, acc_q} + {1'b0, (sreg_q[0] ? opnd_q : '0)};
        acc_n   = add_sum[DATA_W:1];
        sreg_n  = {add_sum[0], sreg_q[DATA_W-1:1]};
`ifdef CONTROL_UNIT_DIV_EN
        shifted = {acc_q, sreg_q[DATA_W-1]};
        ge      = shifted >= {1'b0, opnd_q};
        if (is_div) begin
            // remainder stays below the divisor, so the difference fits DATA_W bits
            acc_n  = ge ? (shifted[DATA_W-1:0] - opnd_q) : shifted[DATA_W-1:0];
            sreg_n = {sreg_q[DATA_W-2:0], ge};
        end
`endif
        res_next = {acc_n, sreg_n};
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc_q  <= '0;
            sreg_q <= a;
            opnd_q <= b;
        end else if (step) begin
            acc_q  <= acc_n;
            sreg_q <= sreg_n;
        end
    end

endmodule

// File: rtl/control_unit_seq.sv
// Sequential calculator control unit: start/busy/done handshake, single-cycle
// ADD/SUB, bit-serial MUL and optional DIV (enabled by CONTROL_UNIT_DIV_EN).
module control_unit_seq
    import control_unit_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int OP_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    control_unit_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W);

    state_t               state_q, state_n;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*DATA_W-1:0]  result_q, quick_res, iter_res;
    logic                 err_q, quick_err;
    logic [OP_W-1:0]      op_in;
    logic [DATA_W:0]      sum, diff;
    logic                 op_legal, is_mul, is_div, long_op, accept, step;
`ifdef CONTROL_UNIT_DIV_EN
    logic                 is_div_q;
`endif

    assign op_in  = bus.input_Operator;
    assign accept = (state_q == ST_IDLE) && bus.start;
    assign step   = (state_q == ST_EXEC);

    always_comb begin
        sum      = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
        diff     = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
        op_legal = 32'(op_in) < 32'd4;
        is_mul   = op_legal && (op_in[1:0] == OP_MUL);
`ifdef CONTROL_UNIT_DIV_EN
        is_div   = op_legal && (op_in[1:0] == OP_DIV) && (bus.operand_b != '0);
`else
        is_div   = 1'b0;
`endif
        long_op   = is_mul || is_div;
        quick_err = 1'b1;
        quick_res = '0;
        // anything that is not ADD/SUB and not iterated is an error case
        if (op_legal && (op_in[1:0] == OP_ADD)) begin
            quick_err = 1'b0;
            quick_res = {{(DATA_W-1){1'b0}}, sum};
        end else if (op_legal && (op_in[1:0] == OP_SUB)) begin
            quick_err = 1'b0;
            quick_res = {{(DATA_W-1){diff[DATA_W]}}, diff};
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_n = long_op ? ST_EXEC : ST_DONE;
            ST_EXEC: if (cnt_q == '0) state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_n;
    end

    // result/err are written on the edge entering DONE and held afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
`ifdef CONTROL_UNIT_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else if (accept) begin
            if (long_op) begin
                cnt_q <= CNT_W'(DATA_W-1);
            end else begin
                result_q <= quick_res;
                err_q    <= quick_err;
            end
`ifdef CONTROL_UNIT_DIV_EN
            is_div_q <= is_div;
`endif
        end else if (step) begin
            if (cnt_q == '0) begin
                result_q <= iter_res;
                err_q    <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    control_unit_iter #(.DATA_W(DATA_W)) u_iter (
        .clk      (clk),
        .load     (accept),
        .step     (step),
`ifdef CONTROL_UNIT_DIV_EN
        .is_div   (is_div_q),
`endif
        .a        (bus.operand_a),
        .b        (bus.operand_b),
        .res_next (iter_res)
    );

    assign bus.busy   = (state_q == ST_EXEC);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_control_unit_seq.sv
// Scoreboard bench for control_unit_seq: driver predicts acceptance and
// pushes expected responses; a monitor pops them when done pulses.
module tb_control_unit_seq;
    localparam int DW = 8;

    typedef struct {
        logic [2*DW-1:0] res;
        bit              err;
        int              acc;
        int              done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   free_edge = 0;
    exp_t sbq[$];

    control_unit_seq_if #(.DATA_W(DW), .OP_W(2)) bus ();

    control_unit_seq #(.DATA_W(DW), .OP_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: what the calculator should answer and how many cycles it takes.
    function automatic exp_t model(input int op, input int a, input int b, input int e);
        exp_t   x;
        longint r;
        int     lat;
        lat   = 1;
        r     = 0;
        x.err = 1'b0;
        case (op)
            0: r = longint'(a) + longint'(b);
            1: r = longint'(a) - longint'(b);
            2: begin r = longint'(a) * longint'(b); lat = DW + 1; end
            default: begin
`ifdef CONTROL_UNIT_DIV_EN
                if (b == 0) x.err = 1'b1;
                else begin
                    r   = (longint'(a % b) << DW) + longint'(a / b);
                    lat = DW + 1;
                end
`else
                x.err = 1'b1;
`endif
            end
        endcase
        x.res      = r[2*DW-1:0];
        x.acc      = e;
        x.done_cyc = e + lat - 1;
        return x;
    endfunction

    // One input cycle; the start is accepted on the next edge only if the
    // reference says the unit is back in idle by then.
    task automatic drive_cycle(input bit s, input int op, input int a, input int b);
        exp_t x;
        @(negedge clk);
        bus.start          = s;
        bus.input_Operator = 2'(op);
        bus.operand_a      = DW'(a);
        bus.operand_b      = DW'(b);
        if (s && (cyc + 1 >= free_edge)) begin
            x = model(op, a, b, cyc + 1);
            sbq.push_back(x);
            free_edge = x.done_cyc + 2;
        end
    endtask

    task automatic idle_until_free();
        while (cyc + 1 < free_edge) drive_cycle(1'b0, $urandom_range(0, 3), $urandom, $urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b0;
        sbq.delete();
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_result", 64'(bus.result), 64'd0);
        check("reset_err", 64'(bus.err), 64'd0);
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        free_edge = cyc + 1;
    endtask

    // Monitor: checks busy every cycle and the response whenever done pulses.
    always begin
        exp_t x;
        bit   busy_exp;
        @(negedge clk);
        #2;
        if (!reset) begin
            busy_exp = (sbq.size() > 0) && (cyc >= sbq[0].acc) && (cyc < sbq[0].done_cyc);
            check("busy", 64'(bus.busy), 64'(busy_exp));
            if (bus.busy && bus.done) check("busy_and_done", 64'd1, 64'd0);
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 64'(bus.done), 64'd0);
                end else begin
                    x = sbq.pop_front();
                    check("done_cycle", 64'(cyc), 64'(x.done_cyc));
                    check("result", 64'(bus.result), 64'(x.res));
                    check("err", 64'(bus.err), 64'(x.err));
                end
            end else if (sbq.size() > 0 && cyc >= sbq[0].done_cyc) begin
                x = sbq.pop_front();
                check("missing_done", 64'(bus.done), 64'd1);
            end
        end
    end

    initial begin
        bus.start          = 1'b0;
        bus.input_Operator = '0;
        bus.operand_a      = '0;
        bus.operand_b      = '0;

        do_reset();

        // directed cases
        drive_cycle(1'b1, 0, 255, 1);   idle_until_free();
        drive_cycle(1'b1, 1, 3, 5);     idle_until_free();
        drive_cycle(1'b1, 2, 255, 255); idle_until_free();
        drive_cycle(1'b1, 3, 200, 7);   idle_until_free();
        drive_cycle(1'b1, 3, 45, 0);    idle_until_free();

        // reset while idle, then mid-multiply
        do_reset();
        drive_cycle(1'b1, 0, 17, 42);   idle_until_free();
        drive_cycle(1'b1, 2, 200, 3);
        repeat (3) drive_cycle(1'b0, 0, 0, 0);
        do_reset();
        drive_cycle(1'b1, 0, 100, 27);  idle_until_free();

        // start pulses while a multiply is busy must be ignored
        drive_cycle(1'b1, 2, 123, 45);
        repeat (4) drive_cycle(1'b1, $urandom_range(0, 3), $urandom, $urandom);
        idle_until_free();

        // start held high, operands alternate between ADD and MUL
        for (int i = 0; i < 40; i++)
            drive_cycle(1'b1, (i % 2 == 0) ? 0 : 2, $urandom_range(0, 255), $urandom_range(0, 255));
        idle_until_free();

        // randomized traffic with idle gaps
        for (int n = 0; n < 150; n++) begin
            int b;
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            drive_cycle(1'b1, $urandom_range(0, 3), $urandom_range(0, 255), b);
            repeat ($urandom_range(0, 10)) drive_cycle(1'b0, $urandom_range(0, 3), $urandom, $urandom);
        end

        for (int i = 0; i < 100 && sbq.size() > 0; i++) drive_cycle(1'b0, 0, 0, 0);
        check("drain_queue", 64'(sbq.size()), 64'd0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
